// File: rtl/combo_entry_ctrl.sv
// Combo-lock sequencer: dials a hex digit, collects NUM_DIGITS entries, checks them against the code, handles error/lockout.
// Optional code programming from the unlocked state is built when COMBO_PROG_EN is defined.
module combo_entry_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter logic [15:0] CODE        = 16'hFACE,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned ERR_CYCLES  = 8,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        dec_i,
  input  logic        enter_i,
  input  logic        prog_i,
  output logic [3:0]  cur_digit,
  output logic [1:0]  digit_idx,
  output logic [15:0] entered,
  output logic [1:0]  led,
  output logic [2:0]  state_o
);

  localparam logic [2:0] ENTRY    = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] UNLOCKED = 3'd2;
  localparam logic [2:0] ERROR    = 3'd3;
  localparam logic [2:0] LOCKOUT  = 3'd4;
  localparam logic [2:0] PROGRAM  = 3'd5;

  localparam int unsigned TMAX = (LOCK_CYCLES > ERR_CYCLES) ? LOCK_CYCLES : ERR_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] ERR_LAST  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_DIGITS - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cur_q, cur_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   ent_q, ent_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   code_reg;
  logic          commit;
  logic          dial;

`ifdef COMBO_PROG_EN
  logic [15:0] code_d;
`else
  logic unused_prog;
  assign unused_prog = prog_i;
  assign code_reg    = CODE;
`endif

  // Enter wins over inc/dec in the same cycle; the digit it captures is the pre-update value.
  assign commit = enter_i && ((state_q == ENTRY) || (state_q == PROGRAM));
  assign dial   = !enter_i && (inc_i ^ dec_i) &&
                  ((state_q == ENTRY) || (state_q == UNLOCKED) || (state_q == PROGRAM));

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    ent_d   = ent_q;
    fail_d  = fail_q;
    timer_d = '0;
`ifdef COMBO_PROG_EN
    code_d  = code_reg;
`endif

    if (dial) begin
      cur_d = inc_i ? cur_q + 4'd1 : cur_q - 4'd1;
    end

    if (commit) begin
      ent_d[{~idx_q, 2'b00} +: 4] = cur_q;
      idx_d = idx_q + 2'd1;
    end

    case (state_q)
      ENTRY: begin
        if (commit && (idx_q == LAST_IDX)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        idx_d = '0;
        if (ent_q == code_reg) begin
          state_d = UNLOCKED;
          fail_d  = '0;
        end else begin
          fail_d  = fail_q + 1'b1;
          state_d = (fail_d == FAIL_MAX) ? LOCKOUT : ERROR;
        end
      end
      UNLOCKED: begin
        if (enter_i) begin
          state_d = ENTRY;
          ent_d   = '0;
`ifdef COMBO_PROG_EN
        end else if (prog_i) begin
          state_d = PROGRAM;
          idx_d   = '0;
`endif
        end
      end
      ERROR: begin
        if (timer_q == ERR_LAST) begin
          state_d = ENTRY;
          timer_d = timer_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = ENTRY;
          fail_d  = '0;
          timer_d = timer_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef COMBO_PROG_EN
      PROGRAM: begin
        if (commit && (idx_q == LAST_IDX)) begin
          code_d  = ent_d;
          state_d = ENTRY;
          idx_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      cur_q   <= '0;
      idx_q   <= '0;
      ent_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      ent_q   <= ent_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

`ifdef COMBO_PROG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      code_reg <= CODE;
    end else begin
      code_reg <= code_d;
    end
  end
`endif

  always_comb begin
    case (state_q)
      UNLOCKED:      led = 2'b01;
      ERROR, LOCKOUT: led = 2'b10;
      PROGRAM:       led = 2'b11;
      default:       led = 2'b00;
    endcase
  end

  assign cur_digit = cur_q;
  assign digit_idx = idx_q;
  assign entered   = ent_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_combo_entry_ctrl.sv
// Directed bench for combo_entry_ctrl with short error/lockout timers.
module tb_combo_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_i = 1'b0;
  logic        dec_i = 1'b0;
  logic        enter_i = 1'b0;
  logic        prog_i = 1'b0;
  logic [3:0]  cur_digit;
  logic [1:0]  digit_idx;
  logic [15:0] entered;
  logic [1:0]  led;
  logic [2:0]  state_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  m_cur = 4'h0;

  localparam logic [2:0] S_ENTRY    = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_UNLOCKED = 3'd2;
  localparam logic [2:0] S_ERROR    = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  combo_entry_ctrl #(
    .NUM_DIGITS (4),
    .CODE       (16'hFACE),
    .MAX_FAIL   (3),
    .ERR_CYCLES (4),
    .LOCK_CYCLES(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (inc_i),
    .dec_i     (dec_i),
    .enter_i   (enter_i),
    .prog_i    (prog_i),
    .cur_digit (cur_digit),
    .digit_idx (digit_idx),
    .entered   (entered),
    .led       (led),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic i, input logic d, input logic e, input logic p);
    inc_i = i; dec_i = d; enter_i = e; prog_i = p;
    @(posedge clk);
    #1;
    inc_i = 1'b0; dec_i = 1'b0; enter_i = 1'b0; prog_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      m_cur = m_cur + 4'd1;
    end
  endtask

  task automatic decs(input int n);
    repeat (n) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      m_cur = m_cur - 4'd1;
    end
  endtask

  task automatic commit();
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d = c[(12 - 4 * k) +: 4];
      while (m_cur != d) incs(1);
      commit();
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle(1);
    chk({tag, "_state"}, {13'd0, state_o}, 16'd0);
    chk({tag, "_cur"}, {12'd0, cur_digit}, 16'd0);
    chk({tag, "_idx"}, {14'd0, digit_idx}, 16'd0);
    chk({tag, "_entered"}, entered, 16'h0000);
    chk({tag, "_led"}, {14'd0, led}, 16'd0);
    rst = 1'b0;
    m_cur = 4'h0;
  endtask

  initial begin
    // Reset state
    do_reset("reset");

    // 1: dial and enter FACE
    decs(1); commit();
    chk("t1_idx_after_first", {14'd0, digit_idx}, 16'd1);
    chk("t1_entered_first", entered, 16'hF000);
    decs(5); commit();
    incs(2); commit();
    incs(2); commit();
    chk("t1_check_state", {13'd0, state_o}, {13'd0, S_CHECK});
    chk("t1_entered", entered, 16'hFACE);
    idle(1);
    chk("t1_unlocked_state", {13'd0, state_o}, {13'd0, S_UNLOCKED});
    chk("t1_led", {14'd0, led}, 16'h0001);
    chk("t1_cur", {12'd0, cur_digit}, 16'h000E);
    chk("t1_idx", {14'd0, digit_idx}, 16'd0);

    // 2: relock, then wrong code CACA
    commit();
    chk("t2_relock_state", {13'd0, state_o}, {13'd0, S_ENTRY});
    chk("t2_relock_led", {14'd0, led}, 16'd0);
    chk("t2_relock_entered", entered, 16'h0000);
    decs(2); commit();
    decs(2); commit();
    incs(2); commit();
    decs(2); commit();
    chk("t2_check_state", {13'd0, state_o}, {13'd0, S_CHECK});
    chk("t2_entered", entered, 16'hCACA);
    idle(1);
    chk("t2_error_state", {13'd0, state_o}, {13'd0, S_ERROR});
    chk("t2_err_led_0", {14'd0, led}, 16'h0002);
    for (int i = 1; i < 4; i++) begin
      idle(1);
      chk("t2_err_led_hold", {14'd0, led}, 16'h0002);
    end
    idle(1);
    chk("t2_err_exit_state", {13'd0, state_o}, {13'd0, S_ENTRY});
    chk("t2_err_exit_led", {14'd0, led}, 16'd0);

    // 4: wrap and priority, then 5a: reset mid-attempt
    do_reset("t4_reset");
    decs(1);
    chk("t4_dec_wrap", {12'd0, cur_digit}, 16'h000F);
    incs(1);
    chk("t4_inc_wrap", {12'd0, cur_digit}, 16'h0000);
    decs(1);
    chk("t4_dec_again", {12'd0, cur_digit}, 16'h000F);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_inc_dec_same", {12'd0, cur_digit}, 16'h000F);
    incs(4);
    chk("t4_cur_3", {12'd0, cur_digit}, 16'h0003);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_enter_inc_slot", entered, 16'h3000);
    chk("t4_enter_inc_cur", {12'd0, cur_digit}, 16'h0003);
    chk("t4_enter_inc_idx", {14'd0, digit_idx}, 16'd1);
    commit();
    chk("t5_two_digits", entered, 16'h3300);
    do_reset("t5_mid_attempt");

    // 3: three wrong codes, lockout with ignored pulses
    enter_code(16'h0000);
    chk("t3_w1_check", {13'd0, state_o}, {13'd0, S_CHECK});
    idle(1);
    chk("t3_w1_error", {13'd0, state_o}, {13'd0, S_ERROR});
    idle(4);
    enter_code(16'h0000);
    idle(1);
    chk("t3_w2_error", {13'd0, state_o}, {13'd0, S_ERROR});
    idle(4);
    enter_code(16'h0000);
    idle(1);
    chk("t3_lock_state", {13'd0, state_o}, {13'd0, S_LOCKOUT});
    chk("t3_lock_led_0", {14'd0, led}, 16'h0002);
    for (int i = 1; i < 20; i++) begin
      step(i[0], 1'b0, ~i[0], 1'b0);
      chk("t3_lock_led_hold", {14'd0, led}, 16'h0002);
      chk("t3_lock_cur_frozen", {12'd0, cur_digit}, 16'h0000);
      chk("t3_lock_idx_frozen", {14'd0, digit_idx}, 16'd0);
    end
    idle(1);
    chk("t3_lock_exit_state", {13'd0, state_o}, {13'd0, S_ENTRY});
    chk("t3_lock_exit_led", {14'd0, led}, 16'd0);
    // fail count restarted: two more failures give ERROR, the third locks again
    enter_code(16'h0000);
    idle(1);
    chk("t3_after_w1_error", {13'd0, state_o}, {13'd0, S_ERROR});
    idle(4);
    enter_code(16'h0000);
    idle(1);
    chk("t3_after_w2_error", {13'd0, state_o}, {13'd0, S_ERROR});
    idle(4);
    enter_code(16'h0000);
    idle(1);
    chk("t3_after_w3_lock", {13'd0, state_o}, {13'd0, S_LOCKOUT});
    idle(5);
    chk("t5_mid_lock_state", {13'd0, state_o}, {13'd0, S_LOCKOUT});
    do_reset("t5_mid_lock");
    enter_code(16'hFACE);
    idle(1);
    chk("t5_face_unlocks", {13'd0, state_o}, {13'd0, S_UNLOCKED});
    chk("t5_face_led", {14'd0, led}, 16'h0001);

    // 6: programming a new code
`ifdef COMBO_PROG_EN
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_prog_state", {13'd0, state_o}, 16'd5);
    chk("t6_prog_led", {14'd0, led}, 16'h0003);
    chk("t6_prog_idx", {14'd0, digit_idx}, 16'd0);
    enter_code(16'h1234);
    chk("t6_prog_done_state", {13'd0, state_o}, {13'd0, S_ENTRY});
    enter_code(16'hFACE);
    idle(1);
    chk("t6_old_code_fails", {13'd0, state_o}, {13'd0, S_ERROR});
    idle(4);
    enter_code(16'h1234);
    idle(1);
    chk("t6_new_code_unlocks", {13'd0, state_o}, {13'd0, S_UNLOCKED});
`else
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_prog_ignored_state", {13'd0, state_o}, {13'd0, S_UNLOCKED});
    chk("t6_prog_ignored_led", {14'd0, led}, 16'h0001);
    commit();
    chk("t6_relock", {13'd0, state_o}, {13'd0, S_ENTRY});
    enter_code(16'hFACE);
    idle(1);
    chk("t6_face_still_unlocks", {13'd0, state_o}, {13'd0, S_UNLOCKED});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
